// File: rtl/halut_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : halut_pkg
//  Description : Shared configuration for the HALUT decoder path. It holds the
//                array geometry (prototypes, codebooks, output columns and
//                decoder units), the address widths derived from it, the
//                command word broadcast to the decoder units, and the state
//                encoding of the decoder sequencer.
//  Contents    : K, C, M, DecoderUnits          - array geometry
//                CAddrWidth, KAddrWidth         - codebook / prototype widths
//                MSlots, MSlotWidth             - column slots per decoder unit
//                dec_cmd_t                      - {c, k, m, first, last}
//                ctrl_state_e                   - IDLE / ISSUE / WAIT_RES
//  Revision    : 1.0 - initial release
// ============================================================================
package halut_pkg;

  localparam int K            = 16;  // prototypes per codebook
  localparam int C            = 32;  // codebooks per row
  localparam int M            = 32;  // output columns
  localparam int DecoderUnits = 16;  // decoder units driven in lockstep

  localparam int CAddrWidth = (C > 1) ? $clog2(C) : 1;
  localparam int KAddrWidth = (K > 1) ? $clog2(K) : 1;
  localparam int MSlots     = M / DecoderUnits;
  // A single slot per unit still gets a 1-bit field so the port never vanishes.
  localparam int MSlotWidth = (MSlots > 1) ? $clog2(MSlots) : 1;

  // Command word seen by every decoder unit.
  typedef struct packed {
    logic [CAddrWidth-1:0] c;
    logic [KAddrWidth-1:0] k;
    logic [MSlotWidth-1:0] m;
    logic                  first;  // clear the accumulator before adding
    logic                  last;   // final command of the row
  } dec_cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2
  } ctrl_state_e;

endpackage : halut_pkg
`default_nettype wire

// File: rtl/halut_decoder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : halut_decoder_ctrl
//  Description : Sequencer between the encoder index stream and the array of
//                decoder units. For each encoded row it accepts one prototype
//                index per codebook, sweeps the column slots owned by every
//                unit and broadcasts (c, k, m) read/accumulate commands. After
//                the last codebook it raises row completion and holds off the
//                next row until the result path consumes it.
//  Ports       : clk_i, rst_ni                  - clock, async active-low reset
//                enc_valid_i/enc_ready_o/enc_k_i - encoder index handshake
//                dec_valid_o/dec_ready_i         - command broadcast handshake
//                dec_c_o/dec_k_o/dec_m_o         - command address fields
//                dec_first_o/dec_last_o          - accumulator clear / row end
//                row_done_valid_o/row_done_ready_i - row completion handshake
//                row_cnt_o                       - completed rows (wraps)
//                stall_cnt_o                     - stalled command cycles
//                                                  (HALUT_DECODER_CTRL_PERF_EN)
//  Options     : HALUT_DECODER_CTRL_PERF_EN - adds the saturating stall counter
//  Revision    : 1.0 - initial release
// ============================================================================
module halut_decoder_ctrl
  import halut_pkg::*;
#(
  parameter int K            = halut_pkg::K,
  parameter int C            = halut_pkg::C,
  parameter int M            = halut_pkg::M,
  parameter int DecoderUnits = halut_pkg::DecoderUnits
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    enc_valid_i,
  output logic                    enc_ready_o,
  input  logic [$clog2(K)-1:0]    enc_k_i,

  output logic                    dec_valid_o,
  input  logic [DecoderUnits-1:0] dec_ready_i,
  output logic [$clog2(C)-1:0]    dec_c_o,
  output logic [$clog2(K)-1:0]    dec_k_o,
  output logic [((M/DecoderUnits) > 1 ? $clog2(M/DecoderUnits) : 1)-1:0] dec_m_o,
  output logic                    dec_first_o,
  output logic                    dec_last_o,

  output logic                    row_done_valid_o,
  input  logic                    row_done_ready_i,
  output logic [15:0]             row_cnt_o
`ifdef HALUT_DECODER_CTRL_PERF_EN
  ,
  output logic [31:0]             stall_cnt_o
`endif
);

  localparam int c_m_slots  = M / DecoderUnits;
  localparam int c_c_width  = $clog2(C);
  localparam int c_k_width  = $clog2(K);
  localparam int c_m_width  = (c_m_slots > 1) ? $clog2(c_m_slots) : 1;

  localparam logic [c_c_width-1:0] c_c_last = c_c_width'(C - 1);
  localparam logic [c_m_width-1:0] c_m_last = c_m_width'(c_m_slots - 1);

  // The column sweep only makes sense if every unit owns the same slot count.
  generate
    if ((M % DecoderUnits) != 0) begin : g_bad_cfg
      $error("halut_decoder_ctrl: M must be a multiple of DecoderUnits");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  ctrl_state_e            r_state;
  ctrl_state_e            w_state_nxt;
  logic [c_c_width-1:0]   r_c;
  logic [c_c_width-1:0]   w_c_nxt;
  logic [c_k_width-1:0]   r_k;
  logic [c_k_width-1:0]   w_k_nxt;
  logic [c_m_width-1:0]   r_m;
  logic [c_m_width-1:0]   w_m_nxt;
  logic [15:0]            r_row_cnt;
  logic [15:0]            w_row_cnt_nxt;

  logic                   w_all_ready;
  logic                   w_m_is_last;
  logic                   w_c_is_last;
  logic                   w_enc_ready;
  logic                   w_dec_valid;
  logic                   w_row_done;

  // A command is only taken when every unit can take it, so the array never
  // diverges: a single slow unit stalls the whole broadcast.
  assign w_all_ready = &dec_ready_i;
  assign w_m_is_last = (r_m == c_m_last);
  assign w_c_is_last = (r_c == c_c_last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_c       <= '0;
      r_k       <= '0;
      r_m       <= '0;
      r_row_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_c       <= w_c_nxt;
      r_k       <= w_k_nxt;
      r_m       <= w_m_nxt;
      r_row_cnt <= w_row_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_c_nxt       = r_c;
    w_k_nxt       = r_k;
    w_m_nxt       = r_m;
    w_row_cnt_nxt = r_row_cnt;
    w_enc_ready   = 1'b0;
    w_dec_valid   = 1'b0;
    w_row_done    = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_enc_ready = 1'b1;
        if (enc_valid_i) begin
          w_k_nxt     = enc_k_i;
          w_m_nxt     = '0;
          w_state_nxt = ISSUE;
        end
      end

      ISSUE: begin
        w_dec_valid = 1'b1;
        if (w_all_ready) begin
          if (!w_m_is_last) begin
            w_m_nxt = r_m + c_m_width'(1);
          end else if (!w_c_is_last) begin
            // Prefetch window: the next codebook's index can be taken in the
            // same cycle the current codebook finishes, so a continuously
            // valid encoder sees back-to-back commands with no IDLE bubble.
            w_enc_ready = 1'b1;
            w_c_nxt     = r_c + c_c_width'(1);
            w_m_nxt     = '0;
            if (enc_valid_i) begin
              w_k_nxt = enc_k_i;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_c_nxt     = '0;
            w_m_nxt     = '0;
            w_state_nxt = WAIT_RES;
          end
        end
      end

      WAIT_RES: begin
        w_row_done = 1'b1;
        if (row_done_ready_i) begin
          w_row_cnt_nxt = r_row_cnt + 16'd1;
          w_state_nxt   = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Reset is folded into the ready so the encoder never sees a ready while
  // the sequencer is held in reset (IDLE would otherwise advertise it).
  assign enc_ready_o      = w_enc_ready & rst_ni;
  assign dec_valid_o      = w_dec_valid;
  assign dec_c_o          = r_c;
  assign dec_k_o          = r_k;
  assign dec_first_o      = w_dec_valid & (r_c == '0);
  assign dec_last_o       = w_dec_valid & w_c_is_last & w_m_is_last;
  assign row_done_valid_o = w_row_done;
  assign row_cnt_o        = r_row_cnt;

  // With one slot per unit every command is the last slot; the field is
  // driven as a constant so downstream logic can optimise it away.
  generate
    if (c_m_slots == 1) begin : g_m_tied
      assign dec_m_o = '0;
    end else begin : g_m_swept
      assign dec_m_o = r_m;
    end
  endgenerate

`ifdef HALUT_DECODER_CTRL_PERF_EN
  // Counts cycles where a command is offered but at least one unit holds it
  // off. Saturates rather than wraps so a long run still reads as "a lot".
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (w_dec_valid && !w_all_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule : halut_decoder_ctrl
`default_nettype wire

// File: tb/tb_halut_decoder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_halut_decoder_ctrl
//  Description : Self-checking bench for halut_decoder_ctrl. Background
//                processes drive the encoder stream and unit readiness and
//                record every transferred command; the main sequence compares
//                each row against the command list expected for the indices
//                that were sent.
//  Options     : HALUT_DECODER_CTRL_PERF_EN - also checks stall_cnt_o
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_halut_decoder_ctrl;

  localparam int NC = 32;  // codebooks
  localparam int NK = 16;  // prototypes
  localparam int NU = 16;  // decoder units
  localparam int MS = 2;   // column slots per unit (32 / 16)

  logic        clk            = 1'b0;
  logic        rst_n          = 1'b0;
  logic        enc_valid      = 1'b0;
  logic [3:0]  enc_k          = '0;
  logic        enc_ready;
  logic        dec_valid;
  logic [15:0] dec_ready      = '1;
  logic [4:0]  dec_c;
  logic [3:0]  dec_k;
  logic [0:0]  dec_m;
  logic        dec_first;
  logic        dec_last;
  logic        row_done_valid;
  logic        row_done_ready = 1'b0;
  logic [15:0] row_cnt;
`ifdef HALUT_DECODER_CTRL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  halut_decoder_ctrl dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enc_valid_i      (enc_valid),
    .enc_ready_o      (enc_ready),
    .enc_k_i          (enc_k),
    .dec_valid_o      (dec_valid),
    .dec_ready_i      (dec_ready),
    .dec_c_o          (dec_c),
    .dec_k_o          (dec_k),
    .dec_m_o          (dec_m),
    .dec_first_o      (dec_first),
    .dec_last_o       (dec_last),
    .row_done_valid_o (row_done_valid),
    .row_done_ready_i (row_done_ready),
    .row_cnt_o        (row_cnt)
`ifdef HALUT_DECODER_CTRL_PERF_EN
    ,
    .stall_cnt_o      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // --------------------------------------------------------------------------
  // Encoder model: presents queued indices, keeps valid and k stable until
  // accepted. enc_hold=1 keeps valid up whenever an index is waiting.
  // --------------------------------------------------------------------------
  int enc_q[$];
  int row_ks[$];
  bit enc_hold    = 1'b1;
  bit hs_prev     = 1'b0;
  int first_hs_cyc = -1;

  initial forever begin
    @(negedge clk);
    hs_prev = enc_valid && enc_ready;
    if (hs_prev && first_hs_cyc < 0) first_hs_cyc = cyc;
    @(posedge clk);
    #1;
    if (hs_prev && enc_q.size() > 0) void'(enc_q.pop_front());
    if (enc_q.size() == 0)          enc_valid = 1'b0;
    else if (!enc_valid || hs_prev) enc_valid = enc_hold || ($urandom_range(0, 2) != 0);
    enc_k = (enc_q.size() > 0) ? 4'(enc_q[0]) : 4'd0;
  end

  // --------------------------------------------------------------------------
  // Unit readiness: 0 = always ready, 1 = random single-unit drop,
  // 2 = unit 5 holds off the (c=7, m=1) command for stall_left cycles.
  // --------------------------------------------------------------------------
  int ready_mode = 0;
  int stall_left = 0;

  initial forever begin
    @(posedge clk);
    #1;
    dec_ready = '1;
    if (ready_mode == 1) begin
      if ($urandom_range(0, 3) == 0) dec_ready[$urandom_range(0, NU-1)] = 1'b0;
    end else if (ready_mode == 2 && stall_left > 0 && dec_valid &&
                 dec_c == 5'd7 && dec_m == 1'b1) begin
      dec_ready[5] = 1'b0;
      stall_left--;
    end
  end

  // --------------------------------------------------------------------------
  // Command collector: records transfers and checks that a stalled command
  // stays offered with identical fields.
  // --------------------------------------------------------------------------
  logic [11:0] got_q[$];
  logic [11:0] prev_cmd;
  logic [11:0] cur_cmd;
  bit          prev_stall      = 1'b0;
  int          stalls          = 0;
  int          last_xfer_cyc   = -1;
  int          first_valid_cyc = -1;
  int          valid_cycles    = 0;

  initial forever begin
    @(negedge clk);
    cur_cmd = {dec_c, dec_k, dec_m, dec_first, dec_last};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(dec_valid), 32'd1);
        check("stall_cmd_frozen", 32'(cur_cmd), 32'(prev_cmd));
      end
      prev_stall = 1'b0;
      if (dec_valid) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (&dec_ready) begin
          got_q.push_back(cur_cmd);
          if (dec_last) last_xfer_cyc = cyc;
        end else begin
          stalls++;
          prev_stall = 1'b1;
          prev_cmd   = cur_cmd;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference: one row is every codebook in order, each swept over all slots,
  // carrying the index sent for that codebook.
  // --------------------------------------------------------------------------
  int exp_rows = 0;

  task automatic push_row(input bit rnd);
    row_ks.delete();
    for (int c = 0; c < NC; c++) begin
      int k = rnd ? int'($urandom_range(0, NK-1)) : (c % NK);
      row_ks.push_back(k);
      enc_q.push_back(k);
    end
  endtask

  task automatic check_row();
    logic [11:0] e;
    check("cmd_count", 32'(got_q.size()), 32'(NC*MS));
    for (int c = 0; c < NC; c++) begin
      for (int m = 0; m < MS; m++) begin
        int idx = c*MS + m;
        e = {5'(c), 4'(row_ks[c]), 1'(m), 1'(c == 0), 1'(c == NC-1 && m == MS-1)};
        if (idx < got_q.size())
          check($sformatf("cmd_c%0d_m%0d", c, m), 32'(got_q[idx]), 32'(e));
      end
    end
    got_q.delete();
  endtask

  task automatic wait_row_done();
    int n = 0;
    @(negedge clk);
    while (!row_done_valid && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("row_done_seen", 32'(row_done_valid), 32'd1);
    check("row_done_delay", 32'(cyc - last_xfer_cyc), 32'd1);
    check_row();
  endtask

  task automatic release_row(input int hold);
    for (int i = 0; i < hold; i++) begin
      check("wait_enc_ready", 32'(enc_ready), 32'd0);
      check("wait_dec_valid", 32'(dec_valid), 32'd0);
      check("wait_row_done", 32'(row_done_valid), 32'd1);
      @(negedge clk);
    end
    @(posedge clk); #1 row_done_ready = 1'b1;
    @(posedge clk); #1 row_done_ready = 1'b0;
    exp_rows = (exp_rows + 1) & 32'hFFFF;
    @(negedge clk);
    check("row_done_fall", 32'(row_done_valid), 32'd0);
    check("row_cnt", 32'(row_cnt), 32'(exp_rows));
  endtask

  task automatic clear_marks();
    first_hs_cyc    = -1;
    first_valid_cyc = -1;
    valid_cycles    = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int stall_base;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_enc_ready", 32'(enc_ready), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_dec_fields", 32'({dec_c, dec_k, dec_m, dec_first, dec_last}), 32'd0);
    check("rst_row_done", 32'(row_done_valid), 32'd0);
    check("rst_row_cnt", 32'(row_cnt), 32'd0);
`ifdef HALUT_DECODER_CTRL_PERF_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_enc_ready", 32'(enc_ready), 32'd1);
    check("idle_dec_valid", 32'(dec_valid), 32'd0);

    // Row 1: k = c % 16, encoder always valid, units always ready
    enc_hold = 1'b1; ready_mode = 0;
    clear_marks();
    push_row(1'b0);
    wait_row_done();
    check("first_cmd_latency", 32'(first_valid_cyc - first_hs_cyc), 32'd1);
    check("row_span_cycles", 32'(last_xfer_cyc - first_valid_cyc), 32'(NC*MS - 1));
    check("row_valid_cycles", 32'(valid_cycles), 32'(NC*MS));
    release_row(0);

    // Row 2: unit 5 stalls the (7,1) command for 3 cycles
    ready_mode = 2; stall_left = 3; stall_base = stalls;
    push_row(1'b1);
    wait_row_done();
    check("stall_cycles", 32'(stalls - stall_base), 32'd3);
`ifdef HALUT_DECODER_CTRL_PERF_EN
    check("stall_cnt_3", stall_cnt, 32'd3);
`endif
    release_row(0);

    // Rows 3-4: random gaps and readiness; result held off 10 cycles while
    // the next row's indices are already waiting
    enc_hold = 1'b0; ready_mode = 1;
    push_row(1'b1);
    wait_row_done();
    push_row(1'b1);
    release_row(10);
    wait_row_done();
`ifdef HALUT_DECODER_CTRL_PERF_EN
    check("stall_cnt_random", stall_cnt, 32'(stalls));
`endif
    release_row(0);

    // Reset in the middle of a row at (c=12, m=0)
    enc_hold = 1'b1; ready_mode = 0;
    push_row(1'b1);
    n = 0;
    @(negedge clk);
    while (!(dec_valid && dec_c == 5'd12 && dec_m == 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_c12_m0", 32'(dec_valid && dec_c == 5'd12), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_enc_ready", 32'(enc_ready), 32'd0);
    check("arst_dec_valid", 32'(dec_valid), 32'd0);
    check("arst_dec_fields", 32'({dec_c, dec_k, dec_m, dec_first, dec_last}), 32'd0);
    check("arst_row_done", 32'(row_done_valid), 32'd0);
    check("arst_row_cnt", 32'(row_cnt), 32'd0);
`ifdef HALUT_DECODER_CTRL_PERF_EN
    check("arst_stall_cnt", stall_cnt, 32'd0);
`endif
    enc_q.delete();
    got_q.delete();
    stalls   = 0;
    exp_rows = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    push_row(1'b1);
    wait_row_done();
    release_row(0);

    // Row counter wrap: preload 0xFFFF, one more row must give 0
    @(negedge clk);
    force dut.r_row_cnt = 16'hFFFF;
    @(posedge clk); #1 release dut.r_row_cnt;
    exp_rows = 32'hFFFF;
    push_row(1'b1);
    wait_row_done();
    release_row(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_halut_decoder_ctrl
`default_nettype wire
